// File: rtl/fetch_if.sv
// ============================================================================
// Module   : fetch_if
// Purpose  : Fetch-stage bus bundle: redirect, instruction memory, decode handoff.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_if;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic        fault;

  // master: the fetch unit; slave: memory plus control/decode
  modport master (
    input  pc_load, pc_target, imem_ack, imem_data, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, opcode, funct, pc, fault
  );

  modport slave (
    output pc_load, pc_target, imem_ack, imem_data, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, opcode, funct, pc, fault
  );
endinterface

`default_nettype wire

// File: rtl/fetch.sv
// ============================================================================
// Module   : fetch
// Purpose  : Instruction fetch stage, one outstanding request, valid/ready out.
//            Optional macro FETCH_ALIGN_CHECK_EN traps misaligned redirects.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic clk,
  input  wire logic rst,
  fetch_if.master   bus
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, VALID = 2'd2, FAULT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, VALID = 2'd2} state_t;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] r_instr;
  logic [31:0] w_next_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_instr <= w_next_instr;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_instr = r_instr;
    case (r_state)
      IDLE: w_next_state = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          w_next_instr = bus.imem_data;
          w_next_state = VALID;
        end
      end
      VALID: begin
        if (bus.instr_ready) begin
          w_next_state = FETCH;
          if (bus.pc_load) begin
`ifdef FETCH_ALIGN_CHECK_EN
            w_next_pc = bus.pc_target;
            if (bus.pc_target[1:0] != 2'b00) begin
              w_next_state = FAULT;
            end
`else
            // Without the trap, silently word-align the redirect
            w_next_pc = bus.pc_target & ~32'h0000_0003;
`endif
          end else begin
            w_next_pc = r_pc + 32'd4;
          end
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: w_next_state = FAULT;
`endif
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.imem_req    = (r_state == FETCH);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == VALID);
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[31:26];
  assign bus.funct       = r_instr[5:0];
  assign bus.pc          = r_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.fault       = (r_state == FAULT);
`else
  assign bus.fault       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ============================================================================
// Module   : tb_fetch
// Purpose  : Directed self-checking bench for fetch with a pc/instr scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pop the oldest expected instruction and compare the held outputs against it
  task automatic check_valid();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("valid", 32'(bus.instr_valid), 32'd1);
      chk("req_in_valid", 32'(bus.imem_req), 32'd0);
      chk("instr", bus.instr, e.ins);
      chk("pc", bus.pc, e.pc);
      chk("opcode", 32'(bus.opcode), 32'(e.ins[31:26]));
      chk("funct", 32'(bus.funct), 32'(e.ins[5:0]));
    end
  endtask

  // Entered at a negedge in FETCH; leaves at a negedge in VALID
  task automatic fetch_to_valid(input int dly, input int hold);
    logic [31:0] d;
    logic [31:0] held;
    chk("req", 32'(bus.imem_req), 32'd1);
    chk("addr", bus.imem_addr, exp_pc);
    chk("valid_in_fetch", 32'(bus.instr_valid), 32'd0);
    chk("fault", 32'(bus.fault), 32'd0);
    for (int i = 0; i < dly; i++) begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = $urandom;
      @(negedge clk);
      chk("req_stable", 32'(bus.imem_req), 32'd1);
      chk("addr_stable", bus.imem_addr, exp_pc);
    end
    d = $urandom;
    bus.imem_data = d;
    bus.imem_ack  = 1'b1;
    sb.push_back('{pc: exp_pc, ins: d});
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    bus.imem_data = $urandom;
    held = bus.instr;
    check_valid();
    for (int i = 0; i < hold; i++) begin
      bus.instr_ready = 1'b0;
      bus.pc_load     = 1'b1;
      bus.pc_target   = 32'h0000_0040;
      bus.imem_ack    = 1'b1;
      bus.imem_data   = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold_instr", bus.instr, held);
      chk("hold_pc", bus.pc, exp_pc);
    end
    bus.imem_ack = 1'b0;
  endtask

  // Entered at a negedge in VALID; leaves at a negedge in FETCH
  task automatic transfer(input logic ld, input logic [31:0] tgt);
    bus.instr_ready = 1'b1;
    bus.pc_load     = ld;
    bus.pc_target   = tgt;
    exp_pc = ld ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_target   = 32'h0;
  endtask

  initial begin
    bus.pc_load     = 1'b0;
    bus.pc_target   = 32'h0;
    bus.imem_ack    = 1'b0;
    bus.imem_data   = 32'h0;
    bus.instr_ready = 1'b0;
    exp_pc          = 32'h0;

    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    rst = 1'b0;
    #1 chk("idle_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);

    // Zero-wait back-to-back: 0, 4, 8
    for (int k = 0; k < 3; k++) begin
      fetch_to_valid(0, 0);
      transfer(1'b0, 32'h0);
    end

    // Delayed ack with toggling data
    fetch_to_valid(3, 0);
    transfer(1'b0, 32'h0);

    // Stall 5 cycles with redirect asserted, then take it
    fetch_to_valid(0, 5);
    transfer(1'b1, 32'h0000_0040);
    chk("redirect_addr", bus.imem_addr, 32'h0000_0040);

    // Wrap at the top of the address space
    fetch_to_valid(1, 0);
    transfer(1'b1, 32'hFFFF_FFFC);
    fetch_to_valid(0, 0);
    transfer(1'b0, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Reset mid-FETCH with ack pulsed during and just after reset
    fetch_to_valid(0, 0);
    transfer(1'b0, 32'h0);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'hDEAD_BEEF;
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(bus.imem_req), 32'd0);
    chk("midrst_instr", bus.instr, 32'h0);
    chk("midrst_pc", bus.pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_instr", bus.instr, 32'h0);
    bus.imem_ack = 1'b0;
    exp_pc = 32'h0;
    fetch_to_valid(1, 0);
    transfer(1'b0, 32'h0);

    // Reset while VALID with ready high: no transfer
    fetch_to_valid(0, 0);
    bus.instr_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("vrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("vrst_pc", bus.pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    exp_pc = 32'h0;
    fetch_to_valid(0, 0);
    transfer(1'b0, 32'h0);

    // Misaligned redirect
    fetch_to_valid(0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    bus.instr_ready = 1'b1;
    bus.pc_load     = 1'b1;
    bus.pc_target   = 32'h0000_0042;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.pc_load     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fault_set", 32'(bus.fault), 32'd1);
      chk("fault_req", 32'(bus.imem_req), 32'd0);
      chk("fault_valid", 32'(bus.instr_valid), 32'd0);
      chk("fault_pc", bus.pc, 32'h0000_0042);
      @(negedge clk);
    end
    rst = 1'b1;
    #1 chk("fault_clr", 32'(bus.fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_pc = 32'h0;
`else
    transfer(1'b1, 32'h0000_0042);
    chk("misalign_addr", bus.imem_addr, 32'h0000_0040);
`endif
    fetch_to_valid(0, 0);
    transfer(1'b0, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
